// File: rtl/cdb_controller.sv
// Common data bus arbiter: one holding slot per FU, ld/st-priority arbitration with ALU round-robin
// and a starvation bound, registered CDB broadcast.
module cdb_controller #(
  parameter int NUM_FU     = 3,
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [NUM_FU-1:0]          fu_sel
);

  localparam int NALU  = NUM_FU - 1;
  localparam int LS    = NUM_FU - 1;
  localparam int RR_W  = (NALU > 1) ? $clog2(NALU) : 1;
  localparam int CW    = RR_W + 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [NUM_FU-1:0] held;
  logic [NUM_FU-1:0] grant;
  logic [TAG_W-1:0]  tag_q  [NUM_FU];
  logic [DATA_W-1:0] data_q [NUM_FU];
  logic [RR_W-1:0]   rr_last;
  logic [RR_W-1:0]   alu_idx;
  logic [CW-1:0]     cand;
  // Remaining ld/st grants allowed while an ALU waits; zero means the ALU must win next.
  logic [CNT_W-1:0]  starve_left;
  logic              alu_pend;
  logic              ls_pend;
  logic              alu_found;
  logic              alu_grant;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    alu_pend  = |held[NUM_FU-2:0];
    ls_pend   = held[LS];
    alu_found = 1'b0;
    alu_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NALU; k++) begin
      cand = {1'b0, rr_last} + CW'(k);
      if (cand >= CW'(NALU)) cand = cand - CW'(NALU);
      if (!alu_found && held[cand]) begin
        alu_found = 1'b1;
        alu_idx   = cand[RR_W-1:0];
      end
    end

    grant     = '0;
    alu_grant = 1'b0;
    if (!flush) begin
      if (ls_pend && !(alu_pend && starve_left == '0)) begin
        grant[LS] = 1'b1;
      end else if (alu_found) begin
        grant[alu_idx] = 1'b1;
        alu_grant      = 1'b1;
      end
    end

    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        sel_tag  = tag_q[i];
        sel_data = data_q[i];
      end
    end
  end

  assign fu_ready = (rst || flush) ? '0 : (~held | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rr_last     <= RR_W'(NALU - 1);
      starve_left <= CNT_W'(STARVE_MAX);
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      fu_sel      <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush) begin
          held[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          held[i]   <= 1'b1;
          tag_q[i]  <= fu_tag[i*TAG_W +: TAG_W];
          data_q[i] <= fu_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end

      if (|grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= sel_tag;
        cdb_data  <= sel_data;
        fu_sel    <= grant;
      end else begin
        cdb_valid <= 1'b0;
        fu_sel    <= '0;
      end

      if (alu_grant) rr_last <= alu_idx;

      if (flush || !alu_pend || alu_grant) begin
        starve_left <= CNT_W'(STARVE_MAX);
      end else if (grant[LS] && starve_left != '0) begin
        starve_left <= starve_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_controller.sv
// Bench for cdb_controller: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_cdb_controller;

  localparam int NUM_FU     = 3;
  localparam int TAG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int NALU       = NUM_FU - 1;
  localparam int LS         = NUM_FU - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     flush = 1'b0;
  logic [NUM_FU-1:0]        fu_valid = '0;
  logic [NUM_FU*TAG_W-1:0]  fu_tag = '0;
  logic [NUM_FU*DATA_W-1:0] fu_data = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [NUM_FU-1:0]        fu_sel;

  cdb_controller #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .fu_sel(fu_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each slot is either empty or holds one result; the CDB is what was picked last edge.
  bit                m_held [NUM_FU];
  logic [TAG_W-1:0]  m_tag  [NUM_FU];
  logic [DATA_W-1:0] m_data [NUM_FU];
  bit                m_acc  [NUM_FU];
  int                m_rr, m_starve, m_g;
  logic [NUM_FU-1:0] m_ready;
  logic              m_cv;
  logic [TAG_W-1:0]  m_ct;
  logic [DATA_W-1:0] m_cd;
  logic [NUM_FU-1:0] m_sel;

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_held[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_acc[i] = 0;
    end
    m_rr = NUM_FU - 2; m_starve = 0; m_g = -1;
    m_cv = 0; m_ct = '0; m_cd = '0; m_sel = '0;
  endtask

  function automatic bit alu_waiting();
    bit p = 0;
    for (int i = 0; i < NALU; i++) p = p | m_held[i];
    return p;
  endfunction

  // Decide this cycle's pick and readiness from the current inputs, then let them settle.
  task automatic eval();
    int c;
    m_g = -1;
    if (!flush && !rst) begin
      if (m_held[LS] && !(alu_waiting() && m_starve == STARVE_MAX)) m_g = LS;
      else if (alu_waiting()) begin
        for (int k = 1; k <= NALU; k++) begin
          c = (m_rr + k) % NALU;
          if (m_g < 0 && m_held[c]) m_g = c;
        end
      end
    end
    for (int i = 0; i < NUM_FU; i++) m_ready[i] = !rst && !flush && (!m_held[i] || m_g == i);
    #1;
  endtask

  task automatic tick();
    bit ap;
    @(posedge clk);
    ap = alu_waiting();
    if (m_g >= 0) begin
      m_cv = 1; m_ct = m_tag[m_g]; m_cd = m_data[m_g]; m_sel = NUM_FU'(1 << m_g);
    end else begin
      m_cv = 0; m_sel = '0;
    end
    if (flush || !ap || (m_g >= 0 && m_g < NALU)) m_starve = 0;
    else if (m_g == LS && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    if (m_g >= 0 && m_g < NALU) m_rr = m_g;
    for (int i = 0; i < NUM_FU; i++) begin
      m_acc[i] = fu_valid[i] && m_ready[i];
      if (flush) m_held[i] = 0;
      else if (m_acc[i]) begin
        m_held[i] = 1; m_tag[i] = fu_tag[i*TAG_W +: TAG_W]; m_data[i] = fu_data[i*DATA_W +: DATA_W];
      end else if (m_g == i) m_held[i] = 0;
    end
    #1;
  endtask

  // Protocol-respecting stimulus: an unaccepted result stays on the inputs unchanged.
  task automatic gen(input logic [NUM_FU-1:0] mask, input int pct);
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i] && !m_acc[i]) continue;
      if (mask[i] && $urandom_range(99) < pct) begin
        fu_valid[i] = 1'b1;
        fu_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
        fu_data[i*DATA_W +: DATA_W] = $urandom;
      end else begin
        fu_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    fu_valid = '0; flush = 1'b0;
    repeat (6) begin eval(); tick(); end
  endtask

  task automatic test_reset();
    fu_valid = 3'b111;
    fu_tag   = {5'h03, 5'h02, 5'h01};
    fu_data  = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== '0) begin
        n_err++; $display("FAIL reset_out: got v=%b sel=%b tag=%h data=%h want all zero", cdb_valid, fu_sel, cdb_tag, cdb_data);
      end
      n_cmp++;
      if (fu_ready !== 3'b000) begin
        n_err++; $display("FAIL reset_ready: got %b want 000", fu_ready);
      end
    end
    model_reset();
    rst = 1'b0;
    eval();
    n_cmp++;
    if (fu_ready !== 3'b111) begin n_err++; $display("FAIL reset_release_ready: got %b want 111", fu_ready); end
    tick();
    fu_valid = '0;
    n_cmp++;
    if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_c1: got valid %b want 0", cdb_valid); end
    eval(); tick();
    n_cmp++;
    if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {1'b1, 3'b100, 5'h03, 32'hC0C0_0003}) begin
      n_err++; $display("FAIL reset_first_bcast: got v=%b sel=%b tag=%h data=%h want 1 100 03 c0c00003", cdb_valid, fu_sel, cdb_tag, cdb_data);
    end
    drain();
  endtask

  task automatic test_single_alu();
    fu_valid = 3'b001;
    fu_tag[0 +: TAG_W] = 5'h0A;
    fu_data[0 +: DATA_W] = 32'hDEAD_BEEF;
    eval(); tick();
    fu_valid = '0;
    n_cmp++;
    if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_c6: got valid %b want 0", cdb_valid); end
    eval(); tick();
    n_cmp++;
    if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {1'b1, 3'b001, 5'h0A, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL single_c7: got v=%b sel=%b tag=%h data=%h want 1 001 0a deadbeef", cdb_valid, fu_sel, cdb_tag, cdb_data);
    end
    eval(); tick();
    n_cmp++;
    if (cdb_valid !== 1'b0 || fu_sel !== 3'b000) begin
      n_err++; $display("FAIL single_c8: got v=%b sel=%b want 0 000", cdb_valid, fu_sel);
    end
    drain();
  endtask

  // Shared per-cycle comparison against the model is written inline in each scenario below.
  task automatic test_round_robin();
    logic [NUM_FU-1:0] prev = '0;
    for (int c = 0; c < 16; c++) begin
      gen(3'b011, 100);
      eval();
      n_cmp++;
      if (fu_ready !== m_ready) begin n_err++; $display("FAIL rr_ready c%0d: got %b want %b", c, fu_ready, m_ready); end
      tick();
      n_cmp++;
      if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {m_cv, m_sel, m_ct, m_cd}) begin
        n_err++; $display("FAIL rr_cdb c%0d: got v=%b sel=%b tag=%h data=%h want %b %b %h %h", c, cdb_valid, fu_sel, cdb_tag, cdb_data, m_cv, m_sel, m_ct, m_cd);
      end
      if (c >= 3) begin
        n_cmp++;
        if (!((fu_sel == 3'b001 || fu_sel == 3'b010) && fu_sel != prev)) begin
          n_err++; $display("FAIL rr_alternate c%0d: got %b after %b want alternating 001/010", c, fu_sel, prev);
        end
      end
      prev = fu_sel;
    end
    drain();
  endtask

  task automatic test_starvation();
    int ls_run = 0;
    for (int c = 0; c < 30; c++) begin
      gen(3'b101, 100);
      eval();
      n_cmp++;
      if (fu_ready !== m_ready) begin n_err++; $display("FAIL starve_ready c%0d: got %b want %b", c, fu_ready, m_ready); end
      tick();
      n_cmp++;
      if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {m_cv, m_sel, m_ct, m_cd}) begin
        n_err++; $display("FAIL starve_cdb c%0d: got v=%b sel=%b tag=%h want %b %b %h", c, cdb_valid, fu_sel, cdb_tag, m_cv, m_sel, m_ct);
      end
      if (fu_sel == 3'b100) ls_run++;
      else if (fu_sel == 3'b001) begin
        if (c > 8) begin
          n_cmp++;
          if (ls_run != STARVE_MAX) begin n_err++; $display("FAIL starve_run c%0d: got %0d ldst grants before alu want %0d", c, ls_run, STARVE_MAX); end
        end
        ls_run = 0;
      end
    end
    drain();
  endtask

  task automatic test_flush();
    fu_valid = 3'b111;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_tag[i*TAG_W +: TAG_W] = TAG_W'(5'h10 + i);
      fu_data[i*DATA_W +: DATA_W] = $urandom;
    end
    eval(); tick();
    fu_valid = '0;
    eval(); tick();
    flush = 1'b1;
    fu_valid = 3'b111;
    eval();
    n_cmp++;
    if (fu_ready !== 3'b000) begin n_err++; $display("FAIL flush_ready_in: got %b want 000", fu_ready); end
    n_cmp++;
    if (cdb_valid !== 1'b1 || fu_sel !== 3'b100) begin
      n_err++; $display("FAIL flush_visible: got v=%b sel=%b want 1 100", cdb_valid, fu_sel);
    end
    tick();
    flush = 1'b0;
    fu_valid = '0;
    eval();
    n_cmp++;
    if (cdb_valid !== 1'b0 || fu_ready !== 3'b111) begin
      n_err++; $display("FAIL flush_after: got v=%b ready=%b want 0 111", cdb_valid, fu_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); eval();
      n_cmp++;
      if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_bcast c%0d: got valid %b want 0", c, cdb_valid); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] want;
    for (int c = 0; c < 6; c++) begin
      fu_valid = (c < 3) ? 3'b010 : 3'b000;
      fu_tag[TAG_W +: TAG_W] = TAG_W'(c + 1);
      fu_data[DATA_W +: DATA_W] = $urandom;
      eval();
      if (c < 3) begin
        n_cmp++;
        if (fu_ready[1] !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", c, fu_ready[1]); end
      end
      tick();
      if (c >= 1 && c <= 3) begin
        want = TAG_W'(c);
        n_cmp++;
        if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {1'b1, 3'b010, want, m_cd}) begin
          n_err++; $display("FAIL b2b_cdb c%0d: got v=%b sel=%b tag=%h data=%h want 1 010 %h %h", c, cdb_valid, fu_sel, cdb_tag, cdb_data, want, m_cd);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      gen(3'b111, 30 + (c / 100) * 20);
      flush = ($urandom_range(24) == 0);
      eval();
      n_cmp++;
      if (fu_ready !== m_ready) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, fu_ready, m_ready); end
      tick();
      n_cmp++;
      if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {m_cv, m_sel, m_ct, m_cd}) begin
        n_err++; $display("FAIL rand_cdb c%0d: got v=%b sel=%b tag=%h data=%h want %b %b %h %h", c, cdb_valid, fu_sel, cdb_tag, cdb_data, m_cv, m_sel, m_ct, m_cd);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_midop_reset();
    for (int c = 0; c < 10; c++) begin
      gen(3'b111, 80); eval(); tick();
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cdb_valid, fu_sel, cdb_tag, cdb_data, fu_ready} !== '0) begin
      n_err++; $display("FAIL midop_reset: got v=%b sel=%b tag=%h data=%h ready=%b want all zero", cdb_valid, fu_sel, cdb_tag, cdb_data, fu_ready);
    end
    fu_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      gen(3'b111, 60);
      eval(); tick();
      n_cmp++;
      if ({cdb_valid, fu_sel, cdb_tag, cdb_data} !== {m_cv, m_sel, m_ct, m_cd}) begin
        n_err++; $display("FAIL midop_after c%0d: got v=%b sel=%b tag=%h want %b %b %h", c, cdb_valid, fu_sel, cdb_tag, m_cv, m_sel, m_ct);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single_alu();
    test_round_robin();
    test_starvation();
    test_flush();
    test_back_to_back();
    test_random();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
